pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_if.sv | 52 +++++
 rtl/pipeline_hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard controller: register numbers and
// stage flags in, stage enables/flushes, forwarding selects, counters out.
// Handshake: there is no valid/ready pair here; mem_ready is a
// completion strobe sampled every cycle, and every output is valid in the
// same cycle as the inputs that produce it.
interface pipeline_hazard_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic [4:0]  exe_rn;
    logic        exe_wreg;
    logic        exe_m2reg;
    logic [4:0]  mem_rn;
    logic        mem_wreg;
    logic        mem_m2reg;
    logic        mem_wmem;
    logic        mem_branch;
    logic        mem_ready;
    logic        pc_we;
    logic        if_id_we;
    logic        id_exe_we;
    logic        exe_mem_we;
    logic        mem_wb_we;
    logic        bubble_id_exe;
    logic        flush_if_id;
    logic        flush_id_exe;
    logic        flush_exe_mem;
    logic        pc_sel_branch;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [15:0] stall_count;
    logic [15:0] flush_count;
    logic        wait_timeout;
    logic [1:0]  state;          // debug view: 0 RUN, 1 WAIT, 2 ERR

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, exe_rn, exe_wreg, exe_m2reg,
               mem_rn, mem_wreg, mem_m2reg, mem_wmem, mem_branch, mem_ready,
        input  pc_we, if_id_we, id_exe_we, exe_mem_we, mem_wb_we, bubble_id_exe,
               flush_if_id, flush_id_exe, flush_exe_mem, pc_sel_branch,
               fwd_a, fwd_b, stall_count, flush_count, wait_timeout, state
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, exe_rn, exe_wreg, exe_m2reg,
               mem_rn, mem_wreg, mem_m2reg, mem_wmem, mem_branch, mem_ready,
        output pc_we, if_id_we, id_exe_we, exe_mem_we, mem_wb_we, bubble_id_exe,
               flush_if_id, flush_id_exe, flush_exe_mem, pc_sel_branch,
               fwd_a, fwd_b, stall_count, flush_count, wait_timeout, state
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: freezes on outstanding data
// memory accesses, flushes on taken branches, stalls on load-use, selects
// operand forwarding and counts stall/flush events.
module pipeline_hazard_ctrl (
    input  logic                  clk,
    input  logic                  clrn,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {S_RUN = 2'd0, S_WAIT = 2'd1, S_ERR = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] stall_q, flush_q;
    logic        timeout_q;

    logic        mem_req, lu, run_rules, do_branch, do_stall;
    logic [4:0]  we;
    logic        bubble, flush, sel_branch;

    // Forwarding priority: EXE ALU result, then MEM ALU result, then MEM load data.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic [4:0] e_rn, input logic e_w, input logic e_m,
                                           input logic [4:0] m_rn, input logic m_w, input logic m_m);
        if (e_w && !e_m && e_rn != 5'd0 && e_rn == src)     fwd_sel = 2'b01;
        else if (m_w && !m_m && m_rn != 5'd0 && m_rn == src) fwd_sel = 2'b10;
        else if (m_w && m_m && m_rn != 5'd0 && m_rn == src)  fwd_sel = 2'b11;
        else                                                 fwd_sel = 2'b00;
    endfunction

    assign mem_req = hz.mem_m2reg | hz.mem_wmem;
    assign lu = hz.exe_wreg & hz.exe_m2reg & (hz.exe_rn != 5'd0) &
                ((hz.id_use_rs & (hz.exe_rn == hz.id_rs)) |
                 (hz.id_use_rt & (hz.exe_rn == hz.id_rt)));

    // Next state, wait counter and stage controls; freeze > branch > load-use.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        run_rules  = 1'b0;
        do_branch  = 1'b0;
        do_stall   = 1'b0;
        we         = 5'b00000;
        bubble     = 1'b0;
        flush      = 1'b0;
        sel_branch = 1'b0;
        case (state_q)
            S_RUN: begin
                if (mem_req && !hz.mem_ready) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = 8'd1;
                end else begin
                    run_rules = 1'b1;
                end
            end
            S_WAIT: begin
                if (hz.mem_ready) begin
                    // release cycle behaves exactly like RUN
                    state_d    = S_RUN;
                    wait_cnt_d = 8'd0;
                    run_rules  = 1'b1;
                end else if (wait_cnt_q == 8'hFF) begin
                    state_d = S_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_RUN;
        endcase
        if (run_rules) begin
            if (hz.mem_branch) begin
                do_branch  = 1'b1;
                we         = 5'b11111;
                flush      = 1'b1;
                sel_branch = 1'b1;
            end else if (lu) begin
                do_stall = 1'b1;
                we       = 5'b00111;
                bubble   = 1'b1;
            end else begin
                we = 5'b11111;
            end
        end
    end

    // State, wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= S_RUN;
            wait_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (state_d == S_ERR) timeout_q <= 1'b1;
        end
    end

    // Saturating stall and flush event counters.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            stall_q <= 16'd0;
            flush_q <= 16'd0;
        end else begin
            if (do_stall && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
            if (do_branch && flush_q != 16'hFFFF) flush_q <= flush_q + 16'd1;
        end
    end

    assign hz.pc_we         = we[4];
    assign hz.if_id_we      = we[3];
    assign hz.id_exe_we     = we[2];
    assign hz.exe_mem_we    = we[1];
    assign hz.mem_wb_we     = we[0];
    assign hz.bubble_id_exe = bubble;
    assign hz.flush_if_id   = flush;
    assign hz.flush_id_exe  = flush;
    assign hz.flush_exe_mem = flush;
    assign hz.pc_sel_branch = sel_branch;
    assign hz.fwd_a = fwd_sel(hz.id_rs, hz.exe_rn, hz.exe_wreg, hz.exe_m2reg,
                              hz.mem_rn, hz.mem_wreg, hz.mem_m2reg);
    assign hz.fwd_b = fwd_sel(hz.id_rt, hz.exe_rn, hz.exe_wreg, hz.exe_m2reg,
                              hz.mem_rn, hz.mem_wreg, hz.mem_m2reg);
    assign hz.stall_count   = stall_q;
    assign hz.flush_count   = flush_q;
    assign hz.wait_timeout  = timeout_q;
    assign hz.state         = state_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: each driven cycle pushes its
// hand-computed expected outputs; a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic clrn = 1'b0;

    // clock
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if hz_if ();
    pipeline_hazard_ctrl dut (.clk(clk), .clrn(clrn), .hz(hz_if));

    // expected vector: {we[4:0], bubble, flush[2:0], sel, fwd_a, fwd_b, timeout, state, stall, flush_cnt}
    logic [48:0] exp_q[$];
    logic        sample_req = 1'b0;
    string       cur_name = "";
    int          n_tests = 0;
    int          n_fail = 0;

    localparam logic [4:0] WE_ALL = 5'b11111;
    localparam logic [4:0] WE_LU  = 5'b00111;
    localparam logic [4:0] WE_NO  = 5'b00000;

    function automatic logic [48:0] pack(input logic [4:0] we, input logic bub, input logic [2:0] fl,
                                         input logic sel, input logic [1:0] fa, input logic [1:0] fb,
                                         input logic to, input logic [1:0] st,
                                         input logic [15:0] sc, input logic [15:0] fc);
        pack = {we, bub, fl, sel, fa, fb, to, st, sc, fc};
    endfunction

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                          input logic [4:0] ern, input logic ew, input logic em,
                          input logic [4:0] mrn, input logic mw, input logic mm, input logic mwm,
                          input logic br, input logic rdy);
        hz_if.id_rs = rs;   hz_if.id_rt = rt;
        hz_if.id_use_rs = urs; hz_if.id_use_rt = urt;
        hz_if.exe_rn = ern; hz_if.exe_wreg = ew; hz_if.exe_m2reg = em;
        hz_if.mem_rn = mrn; hz_if.mem_wreg = mw; hz_if.mem_m2reg = mm; hz_if.mem_wmem = mwm;
        hz_if.mem_branch = br; hz_if.mem_ready = rdy;
    endtask

    task automatic idle_in();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // one checked cycle: inputs already applied, push expectation, advance
    task automatic step(input string name, input logic [48:0] e);
        cur_name = name;
        exp_q.push_back(e);
        sample_req = 1'b1;
        @(posedge clk);
        #1;
        sample_req = 1'b0;
    endtask

    task automatic step_nochk();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        idle_in();
        repeat (2) @(posedge clk);
        #1;
        clrn = 1'b1;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (sample_req) begin
            logic [48:0] act, e;
            n_tests++;
            act = pack({hz_if.pc_we, hz_if.if_id_we, hz_if.id_exe_we, hz_if.exe_mem_we, hz_if.mem_wb_we},
                       hz_if.bubble_id_exe,
                       {hz_if.flush_if_id, hz_if.flush_id_exe, hz_if.flush_exe_mem},
                       hz_if.pc_sel_branch, hz_if.fwd_a, hz_if.fwd_b, hz_if.wait_timeout,
                       hz_if.state, hz_if.stall_count, hz_if.flush_count);
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s: output sampled with empty expected queue, got %h", cur_name, act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %h required %h", cur_name, act, e);
                end
            end
        end
    end

    // watchdog
    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_in();
        do_reset();

        step("reset_idle", pack(WE_ALL, 0, 3'b000, 0, 2'b00, 2'b00, 0, 2'd0, 16'd0, 16'd0));

        // load-use on rs
        set_in(5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 5'd0, 0, 0, 0, 0, 0);
        step("load_use", pack(WE_LU, 1, 3'b000, 0, 2'b00, 2'b00, 0, 2'd0, 16'd0, 16'd0));
        idle_in();
        step("after_lu", pack(WE_ALL, 0, 3'b000, 0, 2'b00, 2'b00, 0, 2'd0, 16'd1, 16'd0));

        // branch wins over concurrent load-use
        set_in(5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 5'd0, 0, 0, 0, 1, 0);
        step("branch_lu", pack(WE_ALL, 0, 3'b111, 1, 2'b00, 2'b00, 0, 2'd0, 16'd1, 16'd0));
        idle_in();
        step("after_branch", pack(WE_ALL, 0, 3'b000, 0, 2'b00, 2'b00, 0, 2'd0, 16'd1, 16'd1));

        // memory wait: 3 frozen cycles then release
        set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 0);
        step("mwait_run", pack(WE_NO, 0, 3'b000, 0, 2'b00, 2'b00, 0, 2'd0, 16'd1, 16'd1));
        step("mwait_w1", pack(WE_NO, 0, 3'b000, 0, 2'b00, 2'b00, 0, 2'd1, 16'd1, 16'd1));
        step("mwait_w2", pack(WE_NO, 0, 3'b000, 0, 2'b00, 2'b00, 0, 2'd1, 16'd1, 16'd1));
        hz_if.mem_ready = 1'b1;
        step("mwait_rel", pack(WE_ALL, 0, 3'b000, 0, 2'b00, 2'b00, 0, 2'd1, 16'd1, 16'd1));
        idle_in();
        step("mwait_back", pack(WE_ALL, 0, 3'b000, 0, 2'b00, 2'b00, 0, 2'd0, 16'd1, 16'd1));

        // branch held during freeze acts on release cycle
        set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 1, 0);
        step("frz_branch", pack(WE_NO, 0, 3'b000, 0, 2'b00, 2'b00, 0, 2'd0, 16'd1, 16'd1));
        hz_if.mem_ready = 1'b1;
        step("rel_branch", pack(WE_ALL, 0, 3'b111, 1, 2'b00, 2'b00, 0, 2'd1, 16'd1, 16'd1));
        idle_in();
        step("after_rel", pack(WE_ALL, 0, 3'b000, 0, 2'b00, 2'b00, 0, 2'd0, 16'd1, 16'd2));

        // forwarding
        set_in(5'd7, 5'd7, 0, 0, 5'd7, 1, 0, 5'd7, 1, 0, 0, 0, 0);
        step("fwd_exe", pack(WE_ALL, 0, 3'b000, 0, 2'b01, 2'b01, 0, 2'd0, 16'd1, 16'd2));
        set_in(5'd7, 5'd7, 0, 0, 5'd0, 1, 0, 5'd7, 1, 0, 0, 0, 0);
        step("fwd_mem", pack(WE_ALL, 0, 3'b000, 0, 2'b10, 2'b10, 0, 2'd0, 16'd1, 16'd2));
        set_in(5'd7, 5'd7, 0, 0, 5'd0, 1, 0, 5'd7, 1, 1, 0, 0, 1);
        step("fwd_load", pack(WE_ALL, 0, 3'b000, 0, 2'b11, 2'b11, 0, 2'd0, 16'd1, 16'd2));
        set_in(5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 5'd0, 1, 0, 0, 0, 0);
        step("fwd_r0", pack(WE_ALL, 0, 3'b000, 0, 2'b00, 2'b00, 0, 2'd0, 16'd1, 16'd2));
        set_in(5'd7, 5'd3, 0, 0, 5'd3, 1, 0, 5'd7, 1, 0, 0, 0, 0);
        step("fwd_mixed", pack(WE_ALL, 0, 3'b000, 0, 2'b10, 2'b01, 0, 2'd0, 16'd1, 16'd2));

        // stall counter saturation
        do_reset();
        set_in(5'd0, 5'd9, 0, 1, 5'd9, 1, 1, 5'd0, 0, 0, 0, 0, 0);
        repeat (65540) step_nochk();
        step("sat_stall", pack(WE_LU, 1, 3'b000, 0, 2'b00, 2'b00, 0, 2'd0, 16'hFFFF, 16'd0));
        idle_in();
        step("sat_hold", pack(WE_ALL, 0, 3'b000, 0, 2'b00, 2'b00, 0, 2'd0, 16'hFFFF, 16'd0));

        // wait timeout
        do_reset();
        set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0);
        step("to_run", pack(WE_NO, 0, 3'b000, 0, 2'b00, 2'b00, 0, 2'd0, 16'd0, 16'd0));
        for (int i = 0; i < 255; i++)
            step("to_wait", pack(WE_NO, 0, 3'b000, 0, 2'b00, 2'b00, 0, 2'd1, 16'd0, 16'd0));
        step("to_err", pack(WE_NO, 0, 3'b000, 0, 2'b00, 2'b00, 1, 2'd2, 16'd0, 16'd0));
        hz_if.mem_ready = 1'b1;
        hz_if.mem_branch = 1'b1;
        step("to_err_rdy", pack(WE_NO, 0, 3'b000, 0, 2'b00, 2'b00, 1, 2'd2, 16'd0, 16'd0));
        step("to_err_hold", pack(WE_NO, 0, 3'b000, 0, 2'b00, 2'b00, 1, 2'd2, 16'd0, 16'd0));
        do_reset();
        step("to_cleared", pack(WE_ALL, 0, 3'b000, 0, 2'b00, 2'b00, 0, 2'd0, 16'd0, 16'd0));

        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
